// File: rtl/uart_pkg.sv
// Shared types and constants for the UART command receiver: FSM states,
// default bit timing, die-select encodings and the command classifier.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 868;

  localparam logic [3:0] DIE_NONE   = 4'b1111;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_SIX  = 8'h36;
  localparam logic [7:0] ASCII_X    = 8'h78;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } rx_state_t;

  typedef enum logic [1:0] {
    CMD_DIE,
    CMD_CLEAR,
    CMD_BAD
  } cmd_kind_t;

  function automatic cmd_kind_t classify_cmd(input logic [7:0] b);
    if (b >= ASCII_ZERO && b <= ASCII_SIX) return CMD_DIE;
    if (b == ASCII_X)                      return CMD_CLEAR;
    return CMD_BAD;
  endfunction

endpackage

// File: rtl/uart_rx_cmd_if.sv
// Serial input plus received-byte and command outputs of the UART receiver.
// The master side drives the line; the slave side is the receiver.
interface uart_rx_cmd_if;

  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic [3:0] o_dieSelect;
  logic       o_rollReq;
  logic       o_cmd_err;
  logic       o_busy;

  modport master (
    output i_rx,
    input  o_data, o_valid, o_frame_err, o_dieSelect, o_rollReq, o_cmd_err, o_busy
  );

  modport slave (
    input  i_rx,
    output o_data, o_valid, o_frame_err, o_dieSelect, o_rollReq, o_cmd_err, o_busy
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit; resets to the
// idle-high level so a reset never looks like a start edge.
module sync2 (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  // NOTE: sequential state is always written with <= so every flop samples
  // its inputs as they were before the edge, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta <= 1'b1;
      o_q  <= 1'b1;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_cmd.sv
// 8N1 UART receiver with mid-bit sampling, break handling and a registered
// ASCII command decoder that drives the die-select code.
module uart_rx_cmd
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_reset,
  uart_rx_cmd_if.slave bus
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

  logic             rx_s;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  sync2 u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (bus.i_rx),
    .o_q     (rx_s)
  );

  assign bus.o_busy = (state != S_IDLE);

  // NOTE: the shift register carries no reset; it is only observed through
  // o_data, which is loaded after all eight bits have been freshly sampled.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state           <= S_IDLE;
      cnt             <= '0;
      bit_idx         <= '0;
      bus.o_data      <= 8'h00;
      bus.o_valid     <= 1'b0;
      bus.o_frame_err <= 1'b0;
    end else begin
      bus.o_valid     <= 1'b0;
      bus.o_frame_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        // Re-check the start bit at its centre to reject short glitches.
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt            <= '0;
            shreg[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) state   <= S_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state       <= S_IDLE;
              bus.o_data  <= shreg;
              bus.o_valid <= 1'b1;
            end else begin
              state           <= S_BREAK;
              bus.o_frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // A held-low line must return high before another start is accepted.
        S_BREAK: begin
          if (rx_s) begin
            state <= S_IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bus.o_dieSelect <= DIE_NONE;
      bus.o_rollReq   <= 1'b0;
      bus.o_cmd_err   <= 1'b0;
    end else begin
      bus.o_rollReq <= 1'b0;
      bus.o_cmd_err <= 1'b0;
      if (bus.o_valid) begin
        unique case (classify_cmd(bus.o_data))
          CMD_DIE: begin
            bus.o_dieSelect <= bus.o_data[3:0];
            bus.o_rollReq   <= 1'b1;
          end
          CMD_CLEAR: bus.o_dieSelect <= DIE_NONE;
          default:   bus.o_cmd_err   <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: doc/uart_rx_cmd.md
UART_RX_CMD -- requirements
Module: uart_rx_cmd

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 i_clk  input  1  single system clock; all logic on rising edge.
REQ-003 i_reset  input  1  reset, synchronous and active-high.
REQ-004 i_rx  input  1  asynchronous UART serial line, idle high, 8N1, LSB first.
REQ-005 o_data  output  8  last correctly framed byte; held until the next valid frame.
REQ-006 o_valid  output  1  one-cycle pulse, o_data newly updated.
REQ-007 o_frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-008 o_dieSelect  output  4  die-select code decoded from commands; 4'b1111 means no die selected.
REQ-009 o_rollReq  output  1  one-cycle pulse, legal die command accepted.
REQ-010 o_cmd_err  output  1  one-cycle pulse, valid byte that is not a legal command.
REQ-011 o_busy  output  1  high in every state except IDLE.

Function
REQ-012 i_rx SHALL pass through a 2-flop synchronizer before use; all sampling uses the synchronized value (rx_s).
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-014 IDLE: rx_s low -> START and clear bit counter; otherwise remain.
REQ-015 START: at count (CLKS_PER_BIT-1)/2, rx_s high -> IDLE (false start, no output pulse); rx_s low -> DATA and clear counter.
REQ-016 DATA: sample rx_s at count CLKS_PER_BIT-1 into shift register bit index 0..7 (LSB first); after index 7 -> STOP.
REQ-017 STOP: sample at count CLKS_PER_BIT-1; high -> IDLE, load o_data, pulse o_valid; low -> BREAK, pulse o_frame_err, o_data unchanged.
REQ-018 BREAK: remain until rx_s high, then -> IDLE; start detection is suppressed in BREAK.
REQ-019 o_valid and o_frame_err SHALL assert the cycle after the stop-bit sample; they are never both high.
REQ-020 Baud counter width SHALL be $clog2(CLKS_PER_BIT); the counter resets to 0 on every state change and never wraps inside a bit.
REQ-021 Command decode, registered on the o_valid cycle: byte 0x30..0x36 ('0'..'6') -> o_dieSelect = byte[3:0], o_rollReq pulses one cycle after o_valid.
REQ-022 Byte 'x' (0x78) -> o_dieSelect = 4'b1111, no o_rollReq; any other byte -> o_cmd_err pulses one cycle after o_valid, o_dieSelect unchanged.
REQ-023 A new start edge is accepted on the first IDLE cycle after STOP; back-to-back frames SHALL be received without loss.
REQ-024 A glitch shorter than CLKS_PER_BIT/2 cycles SHALL cause no output pulse.

Reset
REQ-025 While i_reset is high: state IDLE, counters 0, synchronizer flops 1, o_data 8'h00, o_dieSelect 4'b1111, and all pulses and o_busy 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, reception restarts on the next falling edge of rx_s.

Structure
REQ-027 Shared package uart_pkg SHALL hold the FSM state typedef, the CLKS_PER_BIT default, DIE_NONE = 4'b1111, and the ASCII constants 0x30, 0x36, and 0x78.
REQ-028 The synchronizer SHALL be the sub-module sync2 (1-bit, reset value 1); FSM and decode are in uart_rx_cmd.

Verification (CLKS_PER_BIT = 8)
REQ-029 Send 0x35 ('5') -> o_valid with o_data = 0x35, then o_rollReq with o_dieSelect = 4'b0101 the next cycle.
REQ-030 Send 0x41 ('A') -> o_valid, then o_cmd_err; o_dieSelect stays at its prior value; no o_rollReq.
REQ-031 Send 0x33 with the stop bit driven low, then line high -> o_frame_err only, FSM in BREAK until rx high, o_data unchanged.
REQ-032 3-cycle low glitch on i_rx -> no pulses; o_busy high for fewer than 8 cycles.
REQ-033 Frames '2' and 'x' back-to-back, zero idle gap -> two o_valid pulses, o_dieSelect = 4'b0010 then 4'b1111.
REQ-034 Assert i_reset during DATA bit 4 -> no pulses; the following clean frame 0x31 -> o_dieSelect = 4'b0001.
